// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_FAIL
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  localparam int INHIBIT_CYCLES_DEF = 2500;
  localparam int REQ_CYCLES_DEF     = 50;
  localparam int TIMEOUT_CYCLES_DEF = 375000;
  localparam int FILTER_LEN_DEF     = 8;

  localparam int CNT_W = 19;

  function automatic logic odd_par(
    input logic [7:0] b
  );
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request / completion bundle between a command source and the
// PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  done,
    input  err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output done,
    output err
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Hysteresis filter for one open-drain PS/2 line with a falling-edge
// strobe on the filtered level.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int LEN = FILTER_LEN_DEF
) (
  input  logic clk25,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic [LEN-1:0] sr;

  // Shift register resets to all ones so no edge fires on reset exit.
  always_ff @(posedge clk25 or posedge clr) begin
    if (clr) begin
      sr    <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sr   <= {sr[LEN-2:0], raw};
      fall <= 1'b0;
      if (&sr) begin
        level <= 1'b1;
      end else if (~|sr) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// clocks out start/data/parity/stop on device clock edges, checks ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int REQ_CYCLES     = REQ_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic          clk25,
  input  logic          clr,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2c_in,
  input  logic          ps2d_in,
  output logic          ps2c_oe,
  output logic          ps2d_oe
);

  localparam logic [CNT_W-1:0] INH_LAST =
    CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST =
    CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       bitcnt, bitcnt_n;
  logic [7:0]       data, data_n;
  logic             par, par_n;
  logic             c_oe_n, d_oe_n;
  logic             done_q, done_n;
  logic             timed_out;

  logic c_lvl, c_fall;
  logic d_lvl, d_fall_unused;

  ps2_line_filter #(.LEN(FILTER_LEN)) u_filt_c (
    .clk25 (clk25),
    .clr   (clr),
    .raw   (ps2c_in),
    .level (c_lvl),
    .fall  (c_fall)
  );

  ps2_line_filter #(.LEN(FILTER_LEN)) u_filt_d (
    .clk25 (clk25),
    .clr   (clr),
    .raw   (ps2d_in),
    .level (d_lvl),
    .fall  (d_fall_unused)
  );

  assign bus.tx_ready = (state == S_IDLE);
  assign bus.done     = done_q;
  assign bus.err      = (state == S_FAIL);

  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign timed_out = (cnt >= TO_LAST);

  always_ff @(posedge clk25 or posedge clr) begin
    if (clr) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      data    <= '0;
      par     <= 1'b0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bitcnt  <= bitcnt_n;
      data    <= data_n;
      par     <= par_n;
      ps2c_oe <= c_oe_n;
      ps2d_oe <= d_oe_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    data_n   = data;
    par_n    = par;
    c_oe_n   = ps2c_oe;
    d_oe_n   = ps2d_oe;
    done_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        c_oe_n = 1'b0;
        d_oe_n = 1'b0;
        if (bus.tx_valid) begin
          data_n  = bus.tx_data;
          par_n   = odd_par(bus.tx_data);
          cnt_n   = '0;
          c_oe_n  = 1'b1;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_n = cnt_inc;
        if (cnt == INH_LAST) begin
          d_oe_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        cnt_n = cnt_inc;
        if (cnt == REQ_LAST) begin
          c_oe_n   = 1'b0;
          bitcnt_n = '0;
          cnt_n    = '0;
          state_n  = S_SEND;
        end
      end
      S_SEND: begin
        if (c_fall) begin
          cnt_n    = '0;
          bitcnt_n = bitcnt + 4'd1;
          if (bitcnt < 4'd8) begin
            d_oe_n = ~data[bitcnt[2:0]];
          end else if (bitcnt == 4'd8) begin
            d_oe_n = ~par;
          end else begin
            d_oe_n  = 1'b0;
            state_n = S_ACK;
          end
        end else if (timed_out) begin
          c_oe_n  = 1'b0;
          d_oe_n  = 1'b0;
          state_n = S_FAIL;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_ACK: begin
        if (c_fall) begin
          cnt_n   = '0;
          state_n = d_lvl ? S_FAIL : S_WAIT_IDLE;
        end else if (timed_out) begin
          state_n = S_FAIL;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_WAIT_IDLE: begin
        if (c_lvl && d_lvl) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (c_fall) begin
          cnt_n = '0;
        end else if (timed_out) begin
          state_n = S_FAIL;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_FAIL: begin
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND PS/2 lines with a keyboard model that
// clocks the frame in and optionally ACKs, glitches or stops clocking.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 100;
  localparam int REQ  = 10;
  localparam int TO   = 3000;
  localparam int FL   = 8;
  localparam int HALF = 40;
  localparam int LIM  = INH + REQ + 24 * HALF + 500;

  logic clk25 = 1'b0;
  logic clr   = 1'b0;
  always #20 clk25 = ~clk25;

  ps2_host_tx_if bus();

  logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
  logic dev_c = 1'b0;
  logic dev_d = 1'b0;
  assign ps2c_in = ~(ps2c_oe | dev_c);
  assign ps2d_in = ~(ps2d_oe | dev_d);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk25   (clk25),
    .clr     (clr),
    .bus     (bus),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int acc_cnt  = 0;
  int c_run    = 0;
  int last_c_run = 0;
  logic d_at_rel = 1'b0;
  logic prev_c   = 1'b0;
  bit model_idle = 1'b1;
  int last_fall  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act,
                           input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2) == 0;
    return {1'b1, p, b, 1'b0};
  endfunction

  always @(posedge clk25) begin
    cyc++;
    if (bus.tx_valid && bus.tx_ready && !clr) acc_cnt++;
  end

  always @(negedge clk25) begin
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
    if (ps2c_oe) begin
      c_run++;
    end else begin
      if (prev_c) begin
        last_c_run = c_run;
        d_at_rel   = ps2d_oe;
      end
      c_run = 0;
    end
    prev_c = ps2c_oe;
  end

  // Per-cycle comparison of outputs against what the model says they must be.
  always @(negedge clk25) begin
    chk("done_err_excl", {31'd0, bus.done & bus.err}, 32'd0);
    if (clr) begin
      chk("rst_outputs", {ps2c_oe, ps2d_oe, bus.tx_ready, bus.done,
          bus.err}, 32'b00100);
    end else if (model_idle) begin
      chk("idle_outputs", {ps2c_oe, ps2d_oe, bus.tx_ready},
          32'b001);
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit hold);
    int n;
    n = 0;
    @(posedge clk25); #1;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 1000) begin
      @(posedge clk25); #1;
      n++;
    end
    if (n >= 1000) chk("send_ready_wait", 32'd0, 32'd1);
    @(posedge clk25); #1;
    model_idle = 1'b0;
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  task automatic dev_xfer(input int nclk, input bit ack, input bit glitch,
                          output logic [10:0] fr);
    int n;
    logic hd;
    fr = '1;
    n = 0;
    while (ps2c_in !== 1'b0 && n < 200) begin
      @(negedge clk25); n++;
    end
    if (n >= 200) begin
      chk("dev_wait_inhibit", 32'd0, 32'd1);
      return;
    end
    n = 0;
    while (!(ps2c_in === 1'b1 && ps2d_in === 1'b0) &&
           n < INH + REQ + 100) begin
      @(negedge clk25); n++;
    end
    if (n >= INH + REQ + 100) begin
      chk("dev_wait_rts", 32'd0, 32'd1);
      return;
    end
    fr[0] = ps2d_in;
    cyc_wait(HALF);
    for (int k = 1; k <= nclk; k++) begin
      dev_c = 1'b1;
      last_fall = cyc;
      cyc_wait(HALF - 1);
      @(negedge clk25);
      if (k <= 10) fr[k] = ps2d_in;
      cyc_wait(1);
      dev_c = 1'b0;
      if (k == 10 && ack) dev_d = 1'b1;
      if (k == 11) dev_d = 1'b0;
      if (glitch && k == 3) begin
        cyc_wait(10);
        hd = ps2d_oe;
        dev_c = 1'b1;
        cyc_wait(3);
        dev_c = 1'b0;
        cyc_wait(FL + 4);
        chk("glitch_no_advance", {31'd0, ps2d_oe}, {31'd0, hd});
        cyc_wait(HALF - FL - 17);
      end else begin
        cyc_wait(HALF);
      end
    end
    dev_d = 1'b0;
  endtask

  task automatic wait_pulse(input int lim, output bit d, output bit e,
                            output int at);
    d = 1'b0; e = 1'b0; at = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk25);
      if (bus.done || bus.err) begin
        d = bus.done; e = bus.err; at = cyc;
        break;
      end
    end
    bus.tx_valid = 1'b0;
    if (!d && !e) begin
      chk("pulse_wait", 32'd0, 32'd1);
    end else begin
      @(posedge clk25); #1;
      model_idle = 1'b1;
    end
  endtask

  task automatic run_xfer(input logic [7:0] b, input int nclk,
                          input bit ack, input bit glitch, input bit hold,
                          input int lim, output logic [10:0] fr,
                          output bit d, output bit e, output int at);
    fork
      send(b, hold);
      dev_xfer(nclk, ack, glitch, fr);
      wait_pulse(lim, d, e, at);
    join
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [10:0] fr;
  bit d, e;
  int at, dc0, ec0, ac0;
  logic [7:0] pv [3];

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    #1 clr = 1'b1;
    #2;
    chk("reset_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("reset_oe", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
    chk("reset_pulses", {30'd0, bus.done, bus.err}, 32'd0);
    cyc_wait(3);
    clr = 1'b0;
    cyc_wait(FL + 4);

    // 0xED with ACK
    dc0 = done_cnt; ec0 = err_cnt;
    run_xfer(CMD_SET_LEDS, 11, 1'b1, 1'b0, 1'b0, LIM, fr, d, e, at);
    chk("ed_frame_literal", {21'd0, fr}, {21'd0, 11'h7DA});
    chk("ed_frame_model", {21'd0, fr}, {21'd0, model_frame(8'hED)});
    chk_range("ed_inhibit_len", last_c_run, INH, INH + REQ);
    chk("ed_start_before_release", {31'd0, d_at_rel}, 32'd1);
    chk("ed_done", {30'd0, d, e}, 32'b10);
    cyc_wait(4);
    chk("ed_done_once", done_cnt - dc0, 32'd1);
    chk("ed_no_err", err_cnt - ec0, 32'd0);
    chk("ed_ready_back", {31'd0, bus.tx_ready}, 32'd1);

    // parity corner cases
    pv[0] = 8'h00; pv[1] = 8'h01; pv[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      run_xfer(pv[i], 11, 1'b1, 1'b0, 1'b0, LIM, fr, d, e, at);
      chk($sformatf("par_frame_%02h", pv[i]), {21'd0, fr},
          {21'd0, model_frame(pv[i])});
      chk($sformatf("par_done_%02h", pv[i]), {30'd0, d, e}, 32'b10);
      cyc_wait(4);
    end
    run_xfer(8'h00, 11, 1'b1, 1'b0, 1'b0, LIM, fr, d, e, at);
    chk("par_00_literal", {31'd0, fr[9]}, 32'd1);
    run_xfer(8'h01, 11, 1'b1, 1'b0, 1'b0, LIM, fr, d, e, at);
    chk("par_01_literal", {31'd0, fr[9]}, 32'd0);
    run_xfer(CMD_RESET, 11, 1'b1, 1'b0, 1'b0, LIM, fr, d, e, at);
    chk("par_ff_literal", {31'd0, fr[9]}, 32'd1);
    cyc_wait(4);

    // device omits ACK
    dc0 = done_cnt; ec0 = err_cnt;
    run_xfer(8'h55, 11, 1'b0, 1'b0, 1'b0, LIM, fr, d, e, at);
    chk("noack_pulse", {30'd0, d, e}, 32'b01);
    chk("noack_frame", {21'd0, fr}, {21'd0, model_frame(8'h55)});
    cyc_wait(4);
    chk("noack_no_done", done_cnt - dc0, 32'd0);
    chk("noack_err_once", err_cnt - ec0, 32'd1);
    chk("noack_lines", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);

    // device stops clocking after bit 4
    dc0 = done_cnt;
    run_xfer(8'hA5, 4, 1'b0, 1'b0, 1'b0, LIM + TO, fr, d, e, at);
    chk("to_pulse", {30'd0, d, e}, 32'b01);
    chk_range("to_latency", at - last_fall, TO, TO + FL + 4);
    chk("to_lines", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
    chk("to_no_done", done_cnt - dc0, 32'd0);
    chk("to_err_one_cycle", {31'd0, bus.err}, 32'd0);
    cyc_wait(4);

    // reset in the middle of SEND
    fork
      send(CMD_SET_LEDS, 1'b0);
      dev_xfer(5, 1'b0, 1'b0, fr);
    join
    chk("pre_clr_d_oe", {31'd0, ps2d_oe}, 32'd1);
    @(posedge clk25); #7;
    clr = 1'b1;
    #1;
    chk("clr_lines", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
    chk("clr_ready", {31'd0, bus.tx_ready}, 32'd1);
    model_idle = 1'b1;
    cyc_wait(2);
    clr = 1'b0;
    cyc_wait(FL + 4);
    dc0 = done_cnt;
    run_xfer(CMD_ENABLE, 11, 1'b1, 1'b0, 1'b0, LIM, fr, d, e, at);
    chk("f4_frame_literal", {21'd0, fr}, {21'd0, 11'h5E8});
    chk("f4_done", {30'd0, d, e}, 32'b10);
    cyc_wait(4);
    chk("f4_done_once", done_cnt - dc0, 32'd1);

    // glitches on PS2C and tx_valid held through the transfer
    ac0 = acc_cnt; dc0 = done_cnt;
    run_xfer(8'h3C, 11, 1'b1, 1'b1, 1'b1, LIM, fr, d, e, at);
    chk("glitch_frame", {21'd0, fr}, {21'd0, model_frame(8'h3C)});
    chk("glitch_done", {30'd0, d, e}, 32'b10);
    cyc_wait(6);
    chk("hold_single_accept", acc_cnt - ac0, 32'd1);
    chk("hold_done_once", done_cnt - dc0, 32'd1);
    chk("hold_idle_after", {ps2c_oe, ps2d_oe, bus.tx_ready}, 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
